// File: rtl/sync_fifo_ex.sv
// ---------------------------------------------------------------------------
// sync_fifo_ex -- parametrised single-clock FIFO.
//
// Full 2^depth_bits usable capacity (occupancy tracked by a separate count,
// so pointers need no extra wrap bit), programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode:
//   fwft = 1 : first-word-fall-through, read_data shows the head entry.
//   fwft = 0 : registered read, read_data/read_valid update one cycle after
//              an accepted read_enable.
//
// Ports
//   clk           rising-edge clock for all state
//   reset         synchronous, active-high reset
//   write_data    data to push
//   write_enable  push request
//   read_enable   pop request
//   read_data     head (fwft=1) or last popped word (fwft=0)
//   read_valid    fwft=1: !empty; fwft=0: one-cycle pulse on read_data update
//   empty/full    count == 0 / count == depth
//   almost_empty  count <= almost_empty_level
//   almost_full   count >= almost_full_level
//   count         current occupancy, 0..depth
//   overflow      sticky: a write was dropped
//   underflow     sticky: a read was ignored
//   clear_errors  synchronous clear of overflow/underflow (an error in the
//                 same cycle wins)
// ---------------------------------------------------------------------------
module sync_fifo_ex #(
  parameter int unsigned data_width         = 32,
  parameter int unsigned depth_bits         = 4,
  parameter int unsigned almost_full_level  = (1 << depth_bits) - 1,
  parameter int unsigned almost_empty_level = 1,
  parameter bit          fwft               = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] write_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [data_width-1:0] read_data,
  output logic                  read_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [depth_bits:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  localparam int unsigned depth = 1 << depth_bits;

  typedef logic [depth_bits-1:0] ptr_t;
  typedef logic [depth_bits:0]   cnt_t;

  localparam ptr_t ptr_one   = ptr_t'(1);
  localparam cnt_t cnt_one   = cnt_t'(1);
  localparam cnt_t depth_cnt = cnt_t'(depth);
  localparam cnt_t af_lvl    = cnt_t'(almost_full_level);
  localparam cnt_t ae_lvl    = cnt_t'(almost_empty_level);

  logic [data_width-1:0] mem [depth];
  ptr_t                  write_ptr;
  ptr_t                  read_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  rd_drop;

  // Status is purely a decode of the registered count: no extra latency.
  assign empty        = (count == '0);
  assign full         = (count == depth_cnt);
  assign almost_empty = (count <= ae_lvl);
  assign almost_full  = (count >= af_lvl);

  // A read needs data already stored; a write to a full FIFO is legal only
  // when a read frees the slot in the same cycle (pass-through).
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    rd_drop = 1'b0;
    wr_drop = 1'b0;
    if (read_enable) begin
      rd_acc  = !empty;
      rd_drop = empty;
    end
    if (write_enable) begin
      wr_acc  = !full || rd_acc;
      wr_drop = full && !rd_acc;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define what is valid, and a reset-free array maps
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[write_ptr] <= write_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) write_ptr <= write_ptr + ptr_one;
      if (rd_acc) read_ptr  <= read_ptr + ptr_one;

      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase

      // Clear first, then OR in the new event: set wins on a collision.
      overflow  <= (overflow  && !clear_errors) || wr_drop;
      underflow <= (underflow && !clear_errors) || rd_drop;
    end
  end

  if (fwft) begin : g_fwft
    // Head entry falls through; meaningless while empty.
    assign read_data  = mem[read_ptr];
    assign read_valid = !empty;
  end else begin : g_registered
    logic [data_width-1:0] read_data_q;
    logic                  read_valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        read_data_q  <= '0;
        read_valid_q <= 1'b0;
      end else begin
        read_valid_q <= rd_acc;
        if (rd_acc) read_data_q <= mem[read_ptr];
      end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ex.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ex -- self-checking bench for sync_fifo_ex.
//
// Two instances share the clock:
//   u_a : data_width=8, depth_bits=2, fwft=1 (default thresholds 3 / 1)
//   u_b : data_width=8, depth_bits=3, fwft=0
// A queue per instance holds the expected contents; it is pushed when the
// bench drives an accepted write and popped when a read is accepted.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (fwft) ----------------
  logic       a_reset = 1'b0, a_we = 1'b0, a_re = 1'b0, a_clr = 1'b0;
  logic [7:0] a_wd = '0, a_rd;
  logic       a_rv, a_empty, a_full, a_ae, a_af, a_ov, a_uf;
  logic [2:0] a_count;

  sync_fifo_ex #(.data_width(8), .depth_bits(2), .fwft(1'b1)) u_a (
    .clk(clk), .reset(a_reset), .write_data(a_wd), .write_enable(a_we),
    .read_enable(a_re), .read_data(a_rd), .read_valid(a_rv), .empty(a_empty),
    .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ov), .underflow(a_uf), .clear_errors(a_clr)
  );

  // ---------------- instance B (registered read) ----------------
  logic       b_reset = 1'b0, b_we = 1'b0, b_re = 1'b0, b_clr = 1'b0;
  logic [7:0] b_wd = '0, b_rd;
  logic       b_rv, b_empty, b_full, b_ae, b_af, b_ov, b_uf;
  logic [3:0] b_count;

  sync_fifo_ex #(.data_width(8), .depth_bits(3), .fwft(1'b0)) u_b (
    .clk(clk), .reset(b_reset), .write_data(b_wd), .write_enable(b_we),
    .read_enable(b_re), .read_data(b_rd), .read_valid(b_rv), .empty(b_empty),
    .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ov), .underflow(b_uf), .clear_errors(b_clr)
  );

  // ---------------- scoreboard / model ----------------
  logic [7:0] sb_a [$];
  logic [7:0] sb_b [$];
  logic       ov_a = 1'b0, uf_a = 1'b0;
  logic       ov_b = 1'b0, uf_b = 1'b0;
  logic [7:0] last_b = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic status_a();
    int n;
    n = sb_a.size();
    check("a_count",        32'(a_count), 32'(n));
    check("a_empty",        32'(a_empty), 32'(n == 0));
    check("a_full",         32'(a_full),  32'(n == 4));
    check("a_almost_empty", 32'(a_ae),    32'(n <= 1));
    check("a_almost_full",  32'(a_af),    32'(n >= 3));
    check("a_read_valid",   32'(a_rv),    32'(n != 0));
    check("a_overflow",     32'(a_ov),    32'(ov_a));
    check("a_underflow",    32'(a_uf),    32'(uf_a));
  endtask

  task automatic status_b();
    int n;
    n = sb_b.size();
    check("b_count",        32'(b_count), 32'(n));
    check("b_empty",        32'(b_empty), 32'(n == 0));
    check("b_full",         32'(b_full),  32'(n == 8));
    check("b_almost_empty", 32'(b_ae),    32'(n <= 1));
    check("b_almost_full",  32'(b_af),    32'(n >= 7));
    check("b_overflow",     32'(b_ov),    32'(ov_b));
    check("b_underflow",    32'(b_uf),    32'(uf_b));
  endtask

  // One clock of traffic on A; head data checked before the edge that pops it.
  task automatic op_a(input logic we, input logic re, input logic clr, input logic [7:0] wd);
    logic rd_ok, wr_ok;
    rd_ok = re && (sb_a.size() != 0);
    wr_ok = we && ((sb_a.size() < 4) || rd_ok);
    a_we = we; a_re = re; a_clr = clr; a_wd = wd;
    if (rd_ok) check("a_head_data", 32'(a_rd), 32'(sb_a[0]));
    @(posedge clk); #1;
    a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
    if (rd_ok) void'(sb_a.pop_front());
    if (wr_ok) sb_a.push_back(wd);
    ov_a = (ov_a && !clr) || (we && !wr_ok);
    uf_a = (uf_a && !clr) || (re && !rd_ok);
    status_a();
  endtask

  // One clock of traffic on B; popped data must appear right after the edge.
  task automatic op_b(input logic we, input logic re, input logic [7:0] wd);
    logic rd_ok, wr_ok;
    rd_ok = re && (sb_b.size() != 0);
    wr_ok = we && ((sb_b.size() < 8) || rd_ok);
    b_we = we; b_re = re; b_wd = wd;
    @(posedge clk); #1;
    b_we = 1'b0; b_re = 1'b0;
    if (rd_ok) last_b = sb_b.pop_front();
    if (wr_ok) sb_b.push_back(wd);
    ov_b = ov_b || (we && !wr_ok);
    uf_b = uf_b || (re && !rd_ok);
    check("b_read_valid", 32'(b_rv), 32'(rd_ok));
    check("b_read_data",  32'(b_rd), 32'(last_b));
    status_b();
  endtask

  task automatic reset_a(input int cycles);
    a_reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    a_reset = 1'b0; a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
    sb_a.delete();
    ov_a = 1'b0; uf_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;

    // 1. Reset both instances for two cycles.
    b_reset = 1'b1;
    reset_a(2);
    b_reset = 1'b0;
    sb_b.delete(); last_b = '0;
    status_a();
    status_b();
    check("b_reset_read_valid", 32'(b_rv), 32'(0));
    check("b_reset_read_data",  32'(b_rd), 32'(0));

    // 2. Fill A, overflow attempt, drain in order.
    op_a(1, 0, 0, 8'h11);
    op_a(1, 0, 0, 8'h22);
    op_a(1, 0, 0, 8'h33);
    op_a(1, 0, 0, 8'h44);
    op_a(1, 0, 0, 8'h55);
    for (int i = 0; i < 4; i++) op_a(0, 1, 0, 8'h00);

    // 3. Pass-through on a full FIFO.
    op_a(0, 0, 1, 8'h00);
    op_a(1, 0, 0, 8'h11);
    op_a(1, 0, 0, 8'h22);
    op_a(1, 0, 0, 8'h33);
    op_a(1, 0, 0, 8'h44);
    op_a(1, 1, 0, 8'h99);
    for (int i = 0; i < 4; i++) op_a(0, 1, 0, 8'h00);

    // 4. Read+write on empty: read ignored, write lands and falls through.
    op_a(1, 1, 0, 8'hA5);
    check("a_fwft_after_empty_write", 32'(a_rd), 32'h0000_00A5);
    op_a(0, 0, 1, 8'h00);
    op_a(0, 1, 0, 8'h00);
    op_a(0, 1, 1, 8'h00);   // error and clear together: flag stays set
    op_a(0, 0, 1, 8'h00);

    // 5. Registered read, continuous push/pop with pointer wrap.
    pat = 8'h01;
    for (int i = 0; i < 3; i++) begin op_b(1, 0, pat); pat++; end
    for (int i = 0; i < 20; i++) begin op_b(1, 1, pat); pat++; end
    for (int i = 0; i < 3; i++) op_b(0, 1, 8'h00);
    op_b(0, 0, 8'h00);      // no read: valid drops, data holds

    // 6. Mid-operation reset with count=3 and overflow set.
    op_a(1, 0, 0, 8'hC1);
    op_a(1, 0, 0, 8'hC2);
    op_a(1, 0, 0, 8'hC3);
    op_a(1, 0, 0, 8'hC4);
    op_a(1, 0, 0, 8'hC5);
    op_a(0, 1, 0, 8'h00);
    check("a_pre_reset_count", 32'(a_count), 32'(3));
    a_we = 1'b1; a_wd = 8'hFF;   // reset must win over a pending write
    reset_a(1);
    status_a();
    op_a(1, 0, 0, 8'h7E);
    op_a(0, 1, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
